// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Ports:
//   I_clk    clock, rising edge
//   I_rst    asynchronous active-low reset
//   I_addr   CPU data address; word offset is I_addr[3:2]
//   I_wen    store strobe, one cycle per store
//   I_wdata  store data
//   O_sel    address decode hit (combinational)
//   O_rdata  register read data (combinational), 0 when not selected
//   O_tx     serial output, idle high
//   O_irq    FIFO empty and transmitter idle (registered)
//
// Registers: 0 TXDATA (wo), 1 STATUS, 2 BAUDDIV, 3 reserved.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h00010000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_addr,
    input  logic        I_wen,
    input  logic [31:0] I_wdata,
    output logic        O_sel,
    output logic [31:0] O_rdata,
    output logic        O_tx,
    output logic        O_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [15:0]   r_baud;

    logic [1:0]    r_state;
    logic [7:0]    r_shift;
    logic [15:0]   r_timer;
    logic [15:0]   r_div;
    logic [2:0]    r_bitidx;
    logic          r_tx;
    logic          r_irq;

    logic          w_sel;
    logic          w_we;
    logic [1:0]    w_off;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_tick;
    logic          w_busy;
    logic [CW-1:0] w_count_nxt;
    logic [1:0]    w_state_nxt;
    logic          w_unused;

    assign w_sel      = (I_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = I_addr[3:2];
    assign w_we       = I_wen & w_sel;
    assign w_push_req = w_we & (w_off == 2'd0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // Full is judged on pre-edge state, so a push while full is dropped even if a pop frees a slot.
    assign w_push     = w_push_req & ~w_full;
    assign w_tick     = (r_timer == 16'd0);
    assign w_busy     = (r_state != S_IDLE);
    // Pop from IDLE, or at the very end of a stop bit to chain frames with no idle gap.
    assign w_pop      = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_tick));
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_unused   = ^{I_wdata[31:16], I_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_nxt = S_START;
            S_START: if (w_tick) w_state_nxt = S_DATA;
            S_DATA:  if (w_tick && r_bitidx == 3'd7) w_state_nxt = S_STOP;
            S_STOP:  if (w_tick) w_state_nxt = w_pop ? S_START : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (w_push) r_mem[r_wptr] <= I_wdata[7:0];
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_baud  <= DIV_RESET;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            if (w_push_req && w_full)
                r_ovf <= 1'b1;
            else if (w_we && w_off == 2'd1 && I_wdata[3])
                r_ovf <= 1'b0;
            if (w_we && w_off == 2'd2)
                r_baud <= (I_wdata[15:0] < 16'd2) ? 16'd2 : I_wdata[15:0];
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            r_state  <= S_IDLE;
            r_shift  <= 8'd0;
            r_timer  <= 16'd0;
            r_div    <= 16'd2;
            r_bitidx <= 3'd0;
            r_tx     <= 1'b1;
            r_irq    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
            if (w_pop) begin
                // Divisor is captured per frame so BAUDDIV writes only affect the next frame.
                r_shift  <= r_mem[r_rptr];
                r_div    <= r_baud;
                r_timer  <= r_baud - 16'd1;
                r_bitidx <= 3'd0;
                r_tx     <= 1'b0;
            end else begin
                case (r_state)
                    S_START: begin
                        if (w_tick) begin
                            r_tx    <= r_shift[0];
                            r_timer <= r_div - 16'd1;
                        end else begin
                            r_timer <= r_timer - 16'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_tick) begin
                            r_timer <= r_div - 16'd1;
                            if (r_bitidx == 3'd7) begin
                                r_tx <= 1'b1;
                            end else begin
                                r_shift  <= r_shift >> 1;
                                r_tx     <= r_shift[1];
                                r_bitidx <= r_bitidx + 3'd1;
                            end
                        end else begin
                            r_timer <= r_timer - 16'd1;
                        end
                    end
                    S_STOP: begin
                        if (!w_tick) r_timer <= r_timer - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        O_rdata = 32'd0;
        if (w_sel) begin
            case (w_off)
                2'd1:    O_rdata = {23'd0, 5'(r_count), r_ovf, w_busy, w_empty, w_full};
                2'd2:    O_rdata = {16'd0, r_baud};
                default: O_rdata = 32'd0;
            endcase
        end
    end

    assign O_sel = w_sel;
    assign O_tx  = r_tx;
    assign O_irq = r_irq;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory bus.
- It is the target end of the CPU store/load interface: the CPU writes console bytes to it and polls its status through ordinary loads.
- Bytes are buffered in a FIFO and serialised 8N1, LSB first, on O_tx.
- Gives programs running on the core an observable output channel in simulation and on hardware.

Parameters:
- BASE_ADDR, 32'h00010000: byte address of register 0. The block occupies BASE_ADDR..BASE_ADDR+'hF.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of two, 2..16.
- DIV_RESET, 868: reset value of BAUDDIV, in clocks per bit.

Ports:
- I_clk, in, 1: clock. All state updates on the rising edge.
- I_rst, in, 1: asynchronous, active-low reset.
- I_addr, in, 32: CPU data address (ALU output).
- I_wen, in, 1: store strobe (MemRW=1), one cycle per store.
- I_wdata, in, 32: store data, after the store generator.
- O_sel, out, 1: combinational. High when I_addr[31:4] == BASE_ADDR[31:4]. Used by the load mux.
- O_rdata, out, 32: combinational read data for I_addr[3:2]. Zero when O_sel is low.
- O_tx, out, 1: serial output. Idle high.
- O_irq, out, 1: registered. High when the FIFO is empty and the shifter is idle.

Behaviour:
- Register map (word offset = I_addr[3:2]):
  - 0 TXDATA, write-only: a write pushes I_wdata[7:0]. Reads return 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8:4] count, others 0. Writing 1 to bit3 clears overflow; all other bits are read-only.
  - 2 BAUDDIV: bits[15:0] are read/write, upper bits read 0. A written value below 2 is stored as 2.
  - 3: reserved. Reads 0, writes are ignored.
- A write takes effect only when I_wen=1 and O_sel=1. Byte and halfword stores to TXDATA still push I_wdata[7:0].
- Reset values (I_rst low, asynchronous):
  - O_tx=1, O_irq=1.
  - FIFO empty, count=0, overflow=0, BAUDDIV=DIV_RESET, FSM in IDLE.
  - Reset mid-frame aborts the frame immediately; O_tx returns high with no glitch to 0.
- FIFO behaviour:
  - Circular buffer with wrapping read and write pointers.
  - Full is evaluated from state before the edge.
  - A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
  - A push and a pop on the same edge when not full leave count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head into the shift register, latch BAUDDIV into the bit timer, set O_tx=0 and go to START. This happens on the first edge after the push, so a byte written at edge N produces O_tx low from edge N+1.
  - START: hold for DIV cycles, then go to DATA with O_tx=shift[0].
  - DATA: each bit is held DIV cycles, shifting right. After bit 7, go to STOP with O_tx=1.
  - STOP: hold DIV cycles. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Frame timing: frame length is exactly 10*DIV cycles. DIV is the value latched at frame start; BAUDDIV writes mid-frame apply from the next frame.
- Bit timer: down-counter loaded with DIV-1; the bit ends when the counter reaches 0.
- Counter widths: count is log2(FIFO_DEPTH)+1 bits. The bit timer is 16 bits and the bit index is 3 bits.
- O_irq is recomputed every edge: 1 when empty && next state IDLE.

Test Plan:
- Reset and readback: after reset, read STATUS -> 32'h00000002. Read BAUDDIV -> 868. O_tx=1 throughout.
- Single byte: write BAUDDIV=4, then TXDATA=32'h000000A5.
  - O_tx low from the next edge for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each.
  - Stop bit high. 40 cycles total.
  - busy=1 during the frame. O_irq=1 again at frame end.
- Back-to-back: with DIV=2, write 3 bytes 0x41,0x42,0x43 on consecutive cycles.
  - Count peaks at 2, since the first byte is popped immediately.
  - Three frames of 20 cycles each, with no idle gap between them.
- Overflow: with DIV=1000, write 10 bytes (FIFO_DEPTH=8).
  - STATUS shows full=1, count=8, overflow=1. One byte is in the shifter and one is dropped.
  - Write STATUS=32'h8 -> overflow=0, full unchanged.
- Divisor edge cases:
  - Write BAUDDIV=0 -> reads 2.
  - Write BAUDDIV=6 mid-frame at DIV=4 -> current frame stays 40 cycles, next frame is 60 cycles.
- Decode and reset: a write to BASE_ADDR+'h20 has no effect and O_sel=0. Asserting I_rst low in the middle of the DATA state forces O_tx=1, count=0 and FSM IDLE immediately; after release there is no spurious frame.
